// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter that shares one APB master port between N_REQ requesters.
// Runs the SETUP/ACCESS sequence for the winner and returns rdata/err with a done pulse.
module apb_req_arbiter #(
   parameter int N_REQ   = 2,
   parameter int AW      = 9,
   parameter int DW      = 8,
   parameter int TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N_REQ-1:0]    req,
   input  logic [N_REQ-1:0]    req_write,
   input  logic [N_REQ*AW-1:0] req_addr,
   input  logic [N_REQ*DW-1:0] req_wdata,
   output logic [N_REQ-1:0]    gnt,
   output logic [N_REQ-1:0]    done,
   output logic [DW-1:0]       rdata,
   output logic                err,
   output logic [AW-1:0]       paddr,
   output logic                psel,
   output logic                penable,
   output logic                pwrite,
   output logic [DW-1:0]       pwdata,
   input  logic [DW-1:0]       prdata,
   input  logic                plsverr,
   input  logic                apb_rd_done,
   input  logic                idle
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [PW-1:0]    ptr_q, ptr_d;
   logic [PW-1:0]    own_q, own_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic [N_REQ-1:0] gnt_d, done_d;
   logic [DW-1:0]    rdata_d, pwdata_d;
   logic [AW-1:0]    paddr_d;
   logic             err_d, psel_d, penable_d, pwrite_d;
   logic [PW-1:0]    win, cand;
   logic             found, finish;

   logic [AW-1:0]    addr_a  [N_REQ];
   logic [DW-1:0]    wdata_a [N_REQ];

   for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
      assign addr_a[g]  = req_addr[g*AW +: AW];
      assign wdata_a[g] = req_wdata[g*DW +: DW];
   end

   // First requesting index at or after ptr, wrapping.
   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         cand = PW'((int'(ptr_q) + i) % N_REQ);
         if (!found && req[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      own_d     = own_q;
      timer_d   = timer_q;
      gnt_d     = gnt;
      done_d    = '0;
      rdata_d   = rdata;
      err_d     = err;
      paddr_d   = paddr;
      pwrite_d  = pwrite;
      pwdata_d  = pwdata;
      psel_d    = psel;
      penable_d = penable;
      finish    = 1'b0;
      case (state_q)
         S_IDLE: begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            if (found && idle) begin
               own_d      = win;
               paddr_d    = addr_a[win];
               pwdata_d   = wdata_a[win];
               pwrite_d   = req_write[win];
               gnt_d      = '0;
               gnt_d[win] = 1'b1;
               psel_d     = 1'b1;
               state_d    = S_SETUP;
            end
         end
         S_SETUP: begin
            penable_d = 1'b1;
            timer_d   = '0;
            state_d   = S_ACCESS;
         end
         S_ACCESS: begin
            if (pwrite) begin
               finish  = 1'b1;
               err_d   = plsverr;
               rdata_d = '0;
            end else if (apb_rd_done) begin
               finish  = 1'b1;
               err_d   = plsverr;
               rdata_d = prdata;
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
               // Last allowed ACCESS cycle with no read completion: give up.
               finish  = 1'b1;
               err_d   = 1'b1;
               rdata_d = '0;
            end else begin
               timer_d = timer_q + 1'b1;
            end
            if (finish) begin
               gnt_d     = '0;
               psel_d    = 1'b0;
               penable_d = 1'b0;
               done_d    = gnt;
               state_d   = S_DONE;
            end
         end
         S_DONE: begin
            ptr_d   = (own_q == PW'(N_REQ - 1)) ? '0 : own_q + 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         own_q   <= '0;
         timer_q <= '0;
         gnt     <= '0;
         done    <= '0;
         rdata   <= '0;
         err     <= 1'b0;
         paddr   <= '0;
         pwrite  <= 1'b0;
         pwdata  <= '0;
         psel    <= 1'b0;
         penable <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         own_q   <= own_d;
         timer_q <= timer_d;
         gnt     <= gnt_d;
         done    <= done_d;
         rdata   <= rdata_d;
         err     <= err_d;
         paddr   <= paddr_d;
         pwrite  <= pwrite_d;
         pwdata  <= pwdata_d;
         psel    <= psel_d;
         penable <= penable_d;
      end
   end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: directed and random transfers against a round-robin
// transaction model; done results are queued at grant and popped at completion.
module tb_apb_req_arbiter;

   localparam int N  = 2;
   localparam int AW = 9;
   localparam int DW = 8;
   localparam int TO = 16;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req, req_write;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [N-1:0]    gnt, done;
   logic [DW-1:0]   rdata, pwdata, prdata;
   logic            err, psel, penable, pwrite, plsverr, apb_rd_done, idle;
   logic [AW-1:0]   paddr;

   int vectors     = 0;
   int miscompares = 0;
   int exp_ptr     = 0;
   logic [DW:0] exp_q[$];

   apb_req_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
      .rdata(rdata), .err(err), .paddr(paddr), .psel(psel), .penable(penable),
      .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .plsverr(plsverr),
      .apb_rd_done(apb_rd_done), .idle(idle)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input logic [N-1:0] r, input int p);
      for (int i = 0; i < N; i++)
         if (r[(p + i) % N]) return (p + i) % N;
      return -1;
   endfunction

   task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_write[i]          = wr;
      req_addr[i*AW +: AW]  = a;
      req_wdata[i*DW +: DW] = d;
   endtask

   task automatic scramble_fields();
      for (int i = 0; i < N; i++)
         set_req(i, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_gnt"}, gnt, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_rdata"}, rdata, 0);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_paddr"}, paddr, 0);
      chk({tag, "_psel"}, psel, 0);
      chk({tag, "_penable"}, penable, 0);
      chk({tag, "_pwrite"}, pwrite, 0);
      chk({tag, "_pwdata"}, pwdata, 0);
   endtask

   // One full transfer from IDLE; rd_lat = ACCESS cycle of apb_rd_done (0 = never).
   task automatic run_txn(input logic [N-1:0] rv, input int rd_lat, input int pr, input int pls);
      int w, len;
      logic wr, fpls, eerr;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed, fpr, erd;
      logic [N-1:0] oh;
      logic [DW:0] e;
      w   = pick(rv, exp_ptr);
      wr  = req_write[w];
      ea  = req_addr[w*AW +: AW];
      ed  = req_wdata[w*DW +: DW];
      oh  = '0;
      oh[w] = 1'b1;
      len = wr ? 1 : ((rd_lat >= 1 && rd_lat <= TO) ? rd_lat : TO);
      fpr  = (pr < 0) ? DW'($urandom) : DW'(pr);
      fpls = (pls < 0) ? 1'($urandom_range(0, 1)) : 1'(pls);
      if (wr) begin
         eerr = fpls; erd = '0;
      end else if (rd_lat >= 1 && rd_lat <= TO) begin
         eerr = fpls; erd = fpr;
      end else begin
         eerr = 1'b1; erd = '0;
      end
      exp_q.push_back({eerr, erd});
      req  = rv;
      idle = 1'b1;
      step();
      chk("setup_psel", psel, 1);
      chk("setup_penable", penable, 0);
      chk("setup_gnt", gnt, oh);
      chk("setup_paddr", paddr, ea);
      chk("setup_pwrite", pwrite, wr);
      chk("setup_pwdata", pwdata, ed);
      scramble_fields();
      req = N'($urandom);
      step();
      for (int c = 1; c <= len; c++) begin
         chk("acc_psel", psel, 1);
         chk("acc_penable", penable, 1);
         chk("acc_gnt", gnt, oh);
         chk("acc_paddr", paddr, ea);
         chk("acc_pwrite", pwrite, wr);
         chk("acc_pwdata", pwdata, ed);
         chk("acc_done", done, 0);
         apb_rd_done = !wr && (c == rd_lat);
         prdata      = (c == len) ? fpr : DW'($urandom);
         plsverr     = (c == len) ? fpls : 1'($urandom_range(0, 1));
         step();
      end
      apb_rd_done = 1'b0;
      plsverr     = 1'b0;
      req         = '0;
      e = exp_q.pop_front();
      chk("done_onehot", done, oh);
      chk("done_gnt", gnt, 0);
      chk("done_psel", psel, 0);
      chk("done_penable", penable, 0);
      chk("done_rdata", rdata, e[DW-1:0]);
      chk("done_err", err, e[DW]);
      exp_ptr = (w + 1) % N;
      step();
      chk("gap_psel", psel, 0);
      chk("gap_done", done, 0);
   endtask

   initial begin
      rst_n = 1'b0; req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
      prdata = '0; plsverr = 1'b0; apb_rd_done = 1'b0; idle = 1'b1;
      step();
      step();
      check_all_zero("reset");
      rst_n = 1'b1;
      step();

      // Basic write then read with a 3-cycle read latency.
      set_req(0, 1'b1, 9'h012, 8'hA5);
      run_txn(2'b01, 0, -1, 0);
      set_req(1, 1'b0, 9'h1FF, 8'h00);
      run_txn(2'b10, 3, 8'h3C, 0);

      // Both requesting: ownership alternates.
      for (int i = 0; i < 4; i++) begin
         scramble_fields();
         run_txn(2'b11, $urandom_range(0, 5), -1, -1);
      end

      // Read timeout and the boundary where completion lands on the last cycle.
      set_req(0, 1'b0, 9'h055, 8'h11);
      run_txn(2'b01, 0, -1, 0);
      set_req(0, 1'b0, 9'h0AA, 8'h22);
      run_txn(2'b01, TO, 8'h77, 0);
      set_req(1, 1'b0, 9'h133, 8'h33);
      run_txn(2'b10, TO - 1, 8'h5A, 1);

      // Slave error on a write; bridge busy holds off any grant.
      set_req(1, 1'b1, 9'h0F0, 8'h44);
      run_txn(2'b10, 0, -1, 1);
      idle = 1'b0;
      req  = 2'b11;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("busy_psel", psel, 0);
         chk("busy_gnt", gnt, 0);
      end

      for (int i = 0; i < 30; i++) begin
         scramble_fields();
         run_txn(N'($urandom_range(1, (1 << N) - 1)), $urandom_range(0, 18), -1, -1);
      end

      // Reset during ACCESS: everything drops at once, no done, pointer back to 0.
      set_req(0, 1'b1, 9'h001, 8'h01);
      run_txn(2'b01, 0, -1, 0);
      set_req(1, 1'b0, 9'h1A0, 8'h02);
      req = 2'b10;
      step();
      chk("abort_gnt", gnt, 2'b10);
      step();
      step();
      chk("abort_penable", penable, 1);
      rst_n = 1'b0;
      req   = '0;
      #1;
      check_all_zero("abort");
      step();
      chk("abort_nodone", done, 0);
      rst_n   = 1'b1;
      exp_ptr = 0;
      step();
      chk("post_rst_done", done, 0);
      chk("post_rst_psel", psel, 0);
      scramble_fields();
      run_txn(2'b11, 2, -1, -1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
